bus_dma: RTL

//  Single-channel memory-to-memory DMA engine, word granularity. Occupies bus master port 2
//  (bus requests, address, write data) and bus slave port 5 (CPU-programmed registers).

---
 rtl/bus_dma_pkg.sv | 29 ++
 rtl/bus_dma_regs.sv | 95 +++++++++
 rtl/bus_dma.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bus_dma_pkg.sv
// Shared constants for the single-channel bus DMA engine:
// register map, CTRL bit positions, bus direction codes and FSM states.
package bus_dma_pkg;

    localparam int DMA_LEN_W  = 16;
    localparam int DMA_ADDR_W = 30;
    localparam int DMA_DATA_W = 32;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_SRC  = 2'd1;
    localparam logic [1:0] REG_DST  = 2'd2;
    localparam logic [1:0] REG_LEN  = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int CTRL_DONE  = 2;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RD,
        WR,
        NEXT
    } state_t;

endpackage

// File: rtl/bus_dma_regs.sv
// CPU-facing register file of the DMA engine: slave decode, ready
// generation, SRC/DST/LEN/CTRL storage and done/abort bookkeeping.
module bus_dma_regs
    import bus_dma_pkg::*;
#(
    parameter int LEN_W  = DMA_LEN_W,
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_cs_,
    input  logic              s_as_,
    input  logic              s_rw,
    input  logic [1:0]        s_addr,
    input  logic [DATA_W-1:0] s_wr_data,
    output logic [DATA_W-1:0] s_rd_data,
    output logic              s_rdy_,
    input  logic              busy,
    input  logic              step,
    input  logic              done_set,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [LEN_W-1:0]  len,
    output logic              ie,
    output logic              done,
    output logic              abort,
    output logic              start
);

    logic              rdy_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_mux;
    logic              access;
    logic              wr;
    logic              ctrl_wr;
    logic              unused_bits;

    // An access is taken once; the cycle showing ready blocks a re-take.
    assign access  = !s_cs_ && !s_as_ && rdy_q;
    assign wr      = access && (s_rw == WRITE);
    assign ctrl_wr = wr && (s_addr == REG_CTRL);
    assign start   = ctrl_wr && s_wr_data[CTRL_START] && !busy;

    assign s_rdy_      = rdy_q;
    assign s_rd_data   = rd_q;
    assign unused_bits = ^s_wr_data[DATA_W-1:ADDR_W];

    always_comb begin
        rd_mux = '0;
        unique case (s_addr)
            REG_CTRL: rd_mux = DATA_W'({done, ie, busy});
            REG_SRC:  rd_mux = DATA_W'(src);
            REG_DST:  rd_mux = DATA_W'(dst);
            REG_LEN:  rd_mux = DATA_W'(len);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q <= 1'b1;
            rd_q  <= '0;
            src   <= '0;
            dst   <= '0;
            len   <= '0;
            ie    <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
        end else begin
            rdy_q <= !access;
            rd_q  <= (access && s_rw == READ) ? rd_mux : '0;
            if (step) begin
                src <= src + ADDR_W'(1);
                dst <= dst + ADDR_W'(1);
                len <= len - LEN_W'(1);
            end else if (wr && !busy) begin
                case (s_addr)
                    REG_SRC: src <= s_wr_data[ADDR_W-1:0];
                    REG_DST: dst <= s_wr_data[ADDR_W-1:0];
                    REG_LEN: len <= s_wr_data[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (ctrl_wr) begin
                ie <= s_wr_data[CTRL_IE];
            end
            // A completion in the same cycle as the W1C keeps done set.
            done  <= done_set ||
                     (done && !(ctrl_wr && s_wr_data[CTRL_DONE]));
            abort <= busy &&
                     (abort || (ctrl_wr && !s_wr_data[CTRL_START]));
        end
    end

endmodule

// File: rtl/bus_dma.sv
// Single-channel word-granular memory-to-memory DMA engine: copies LEN
// words from SRC to DST through arbitrated read/write pairs.
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int LEN_W  = DMA_LEN_W,
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_cs_,
    input  logic              s_as_,
    input  logic              s_rw,
    input  logic [1:0]        s_addr,
    input  logic [DATA_W-1:0] s_wr_data,
    output logic [DATA_W-1:0] s_rd_data,
    output logic              s_rdy_,
    output logic              m_req_,
    input  logic              m_grnt_,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_as_,
    output logic              m_rw,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rdy_,
    output logic              irq
);

    state_t            state;
    state_t            state_n;
    logic              busy;
    logic              step;
    logic              done_set;
    logic              start;
    logic              abort;
    logic              ie;
    logic              done;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic              req_q;
    logic              as_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] buf_q;

    bus_dma_regs #(
        .LEN_W (LEN_W),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_regs (
        .clk      (clk),
        .reset    (reset),
        .s_cs_    (s_cs_),
        .s_as_    (s_as_),
        .s_rw     (s_rw),
        .s_addr   (s_addr),
        .s_wr_data(s_wr_data),
        .s_rd_data(s_rd_data),
        .s_rdy_   (s_rdy_),
        .busy     (busy),
        .step     (step),
        .done_set (done_set),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .ie       (ie),
        .done     (done),
        .abort    (abort),
        .start    (start)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_n  = state;
        step     = 1'b0;
        done_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) state_n = REQ;
                    else           done_set = 1'b1;
                end
            end
            REQ: begin
                if (abort)         state_n = IDLE;
                else if (!m_grnt_) state_n = RD;
            end
            RD: if (!m_rdy_) state_n = WR;
            WR: if (!m_rdy_) state_n = NEXT;
            NEXT: begin
                step = 1'b1;
                // Completion takes priority over a pending abort.
                if (len == LEN_W'(1)) begin
                    done_set = 1'b1;
                    state_n  = IDLE;
                end else if (abort) begin
                    state_n = IDLE;
                end else begin
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they change
    // only on clock edges; req_ drops for the single NEXT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            req_q  <= 1'b1;
            as_q   <= 1'b1;
            rw_q   <= READ;
            addr_q <= '0;
            buf_q  <= '0;
        end else begin
            state  <= state_n;
            req_q  <= !(state_n inside {REQ, RD, WR});
            as_q   <= !(state_n inside {RD, WR});
            rw_q   <= (state_n == WR) ? WRITE : READ;
            if (state_n == RD)      addr_q <= src;
            else if (state_n == WR) addr_q <= dst;
            if (state == RD && !m_rdy_) buf_q <= m_rd_data;
        end
    end

    assign m_req_    = req_q;
    assign m_as_     = as_q;
    assign m_rw      = rw_q;
    assign m_addr    = addr_q;
    assign m_wr_data = buf_q;
    assign irq       = done && ie;

endmodule
